// File: rtl/instruction_loader.sv
// instruction_loader: streams a count-prefixed byte program into a 32-bit instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, FINISH} state_t;
  localparam state_t LAST_NEXT = CHECK;
`else
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, FINISH} state_t;
  localparam state_t LAST_NEXT = FINISH;
`endif
  state_t state, state_n;
  logic [7:0] n, word_idx;
  logic [1:0] byte_idx;
  logic [31:0] word;
  logic accept, last, count_bad;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign in_ready = state inside {COUNT, DATA, CHECK};
`else
  assign in_ready = state inside {COUNT, DATA};
`endif
  assign accept = in_valid && in_ready;
  assign last = word_idx + 8'd1 == n;
  assign count_bad = in_byte == 8'd0 || {24'd0, in_byte} > DEPTH;
  assign wr_en = state == WRITE;
  assign done = state == FINISH;
  assign busy = state != IDLE && state != FINISH;
  assign cpu_reset = busy;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = start ? COUNT : IDLE;
      COUNT:  state_n = accept ? (count_bad ? FINISH : DATA) : COUNT;
      DATA:   state_n = accept && byte_idx == 2'd3 ? WRITE : DATA;
      WRITE:  state_n = last ? LAST_NEXT : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHECK:  state_n = accept ? FINISH : CHECK;
`endif
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Words are assembled by shifting in at the top, so the first byte lands in bits 7:0.
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      if (state == IDLE && start) err <= 1'b0;
      if (state == COUNT && accept) begin
        n <= in_byte;
        word_idx <= '0;
        byte_idx <= '0;
        if ({24'd0, in_byte} > DEPTH) err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == DATA && accept) begin
        word <= {in_byte, word[31:8]};
        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ in_byte;
`endif
        if (byte_idx == 2'd3) begin
          wr_addr <= {22'd0, word_idx, 2'b00};
          wr_data <= {in_byte, word[31:8]};
        end
      end
      if (state == WRITE) word_idx <= word_idx + 8'd1;
`ifdef LOADER_CHECKSUM_EN
      if (state == CHECK && accept && in_byte != csum) err <= 1'b1;
`endif
    end
  end
endmodule
